varredor_mux8: RTL and testbench

- Sequential scan controller paired with the 8:1 one-bit multiplexer.
- Drives the mux select lines Sel2..Sel0 through codes 0..7 and samples the mux output S on each code.
- Assembles the eight sampled bits into a parallel word, i.e. reads the mux's eight data inputs through its single output.
- Start/busy/done handshake toward the control logic upstream.

---
 rtl/varredor_mux8_if.sv | 34 +++
 rtl/varredor_mux8.sv | 109 ++++++++++
 tb/tb_varredor_mux8.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/varredor_mux8_if.sv
// Interface between the scan controller and its surroundings: the start/busy/done
// handshake upstream, plus the select lines and sampled output of the 8:1 mux.
// Optional macro VARREDOR_MUX8_PARIDADE_EN adds the Paridade signal.
interface varredor_mux8_if;
   logic       Iniciar;
   logic       S;
   logic       Sel0;
   logic       Sel1;
   logic       Sel2;
   logic [7:0] Dados;
   logic       Ocupado;
   logic       Pronto;
`ifdef VARREDOR_MUX8_PARIDADE_EN
   logic       Paridade;
`endif

   // Control side: requests scans, drives the mux output under test.
   modport master (
      output Iniciar, S,
      input  Sel0, Sel1, Sel2, Dados, Ocupado, Pronto
`ifdef VARREDOR_MUX8_PARIDADE_EN
      , input Paridade
`endif
   );

   // Scan controller side.
   modport slave (
      input  Iniciar, S,
      output Sel0, Sel1, Sel2, Dados, Ocupado, Pronto
`ifdef VARREDOR_MUX8_PARIDADE_EN
      , output Paridade
`endif
   );
endinterface

// File: rtl/varredor_mux8.sv
// varredor_mux8: steps an 8:1 mux through select codes 0..7, holding each code
// for ESPERA+1 cycles and sampling S on the last cycle of each code, then
// publishes the eight sampled bits as one word with a one-cycle Pronto pulse.
// Optional macro VARREDOR_MUX8_PARIDADE_EN adds a registered even-parity output.
module varredor_mux8 #(
   parameter int unsigned ESPERA = 0   // extra settle cycles per code, 0..15
) (
   input logic           Clock,
   input logic           Reset,
   varredor_mux8_if.slave bus
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      VARRE   = 2'd1,
      CONCLUI = 2'd2
   } estado_t;

   localparam logic [3:0] ULTIMO = 4'(ESPERA);

   estado_t    estado, estado_n;
   logic [2:0] indice, indice_n;
   logic [3:0] conta, conta_n;
   logic [7:0] sombra, sombra_n;
   logic [7:0] dados, dados_n;

   // Next-state logic: settle counting, sampling of S and word hand-off.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      estado_n = estado;
      indice_n = indice;
      conta_n  = conta;
      sombra_n = sombra;
      dados_n  = dados;
      unique case (estado)
         OCIOSO: begin
            if (bus.Iniciar) begin
               estado_n = VARRE;
               indice_n = 3'd0;
               conta_n  = 4'd0;
               sombra_n = 8'h00;
            end
         end
         VARRE: begin
            if (conta == ULTIMO) begin
               // Last cycle of this code: the mux output has settled.
               // NOTE: blocking assignments here so dados_n below sees the
               // bit just written into sombra_n in the same evaluation.
               sombra_n[indice] = bus.S;
               conta_n          = 4'd0;
               if (indice == 3'd7) begin
                  estado_n = CONCLUI;
                  dados_n  = sombra_n;
               end else begin
                  indice_n = indice + 3'd1;
               end
            end else begin
               conta_n = conta + 4'd1;
            end
         end
         CONCLUI: begin
            estado_n = OCIOSO;
            indice_n = 3'd0;
         end
         default: estado_n = OCIOSO;
      endcase
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge Clock) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (Reset) begin
         estado <= OCIOSO;
         indice <= 3'd0;
         conta  <= 4'd0;
         sombra <= 8'h00;
         dados  <= 8'h00;
      end else begin
         estado <= estado_n;
         indice <= indice_n;
         conta  <= conta_n;
         sombra <= sombra_n;
         dados  <= dados_n;
      end
   end

`ifdef VARREDOR_MUX8_PARIDADE_EN
   logic paridade;

   // Parity register loads alongside Dados; holds otherwise since ^dados_n == ^dados.
   always_ff @(posedge Clock) begin
      if (Reset) paridade <= 1'b0;
      else       paridade <= ^dados_n;
   end

   assign bus.Paridade = paridade;
`endif

   // Outputs are pure decodes of registered state, so they change only at the edge.
   assign bus.Sel0    = (estado == VARRE) & indice[0];
   assign bus.Sel1    = (estado == VARRE) & indice[1];
   assign bus.Sel2    = (estado == VARRE) & indice[2];
   assign bus.Ocupado = (estado != OCIOSO);
   assign bus.Pronto  = (estado == CONCLUI);
   assign bus.Dados   = dados;

endmodule

// File: tb/tb_varredor_mux8.sv
// Bench for varredor_mux8: two instances (ESPERA = 0 and ESPERA = 3), each with a
// modelled 8:1 mux on S. A cycle-count model predicts every output; a compare
// process checks it on each falling edge, and directed tests add literal checks.
module tb_varredor_mux8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   varredor_mux8_if bus0 ();
   varredor_mux8_if bus3 ();

   varredor_mux8 #(.ESPERA(0)) dut0 (.Clock(clk), .Reset(rst), .bus(bus0));
   varredor_mux8 #(.ESPERA(3)) dut3 (.Clock(clk), .Reset(rst), .bus(bus3));

   // Stimulus per instance: index 0 -> dut0, index 1 -> dut3.
   logic       ini    [2] = '{1'b0, 1'b0};
   logic [7:0] mux    [2] = '{8'h00, 8'h00};
   logic       glitch [2] = '{1'b0, 1'b0};
   logic       glitch_on  = 1'b0;

   logic [2:0] sel_w    [2];
   logic       ocup_w   [2];
   logic       pronto_w [2];
   logic [7:0] dados_w  [2];

   assign sel_w[0]    = {bus0.Sel2, bus0.Sel1, bus0.Sel0};
   assign sel_w[1]    = {bus3.Sel2, bus3.Sel1, bus3.Sel0};
   assign ocup_w[0]   = bus0.Ocupado;
   assign ocup_w[1]   = bus3.Ocupado;
   assign pronto_w[0] = bus0.Pronto;
   assign pronto_w[1] = bus3.Pronto;
   assign dados_w[0]  = bus0.Dados;
   assign dados_w[1]  = bus3.Dados;

   assign bus0.Iniciar = ini[0];
   assign bus3.Iniciar = ini[1];
   assign bus0.S       = mux[0][sel_w[0]] ^ glitch[0];
   assign bus3.S       = mux[1][sel_w[1]] ^ glitch[1];

`ifdef VARREDOR_MUX8_PARIDADE_EN
   logic par_w [2];
   assign par_w[0] = bus0.Paridade;
   assign par_w[1] = bus3.Paridade;
`endif

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // t = cycles elapsed since the start edge: -1 idle, 0..len-1 scanning,
   // len = the single done cycle. Code held in cycle t is t/(E+1).
   int         esp      [2] = '{0, 3};
   int         t        [2] = '{-1, -1};
   logic [7:0] m_dados  [2] = '{8'h00, 8'h00};
   logic [7:0] m_shadow [2] = '{8'h00, 8'h00};
   logic       s_lat    [2];

   function automatic int scan_len(input int e);
      return 8 * (e + 1);
   endfunction

   // S is stable from shortly after the falling edge up to the next rising edge.
   always @(negedge clk) begin
      #2;
      s_lat[0] = bus0.S;
      s_lat[1] = bus3.S;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            t[i] = -1;
            m_dados[i] = 8'h00;
            m_shadow[i] = 8'h00;
         end else if (t[i] < 0) begin
            if (ini[i]) begin
               t[i] = 0;
               m_shadow[i] = 8'h00;
            end
         end else if (t[i] < scan_len(esp[i])) begin
            if (t[i] % (esp[i] + 1) == esp[i]) m_shadow[i][t[i] / (esp[i] + 1)] = s_lat[i];
            t[i]++;
            if (t[i] == scan_len(esp[i])) m_dados[i] = m_shadow[i];
         end else begin
            t[i] = -1;
         end
      end
   end

   // Compare process; also injects S glitches on non-final settle cycles.
   always @(negedge clk) begin
      if (n_vec > 0 || !rst) begin
         for (int i = 0; i < 2; i++) begin
            int len;
            len = scan_len(esp[i]);
            if (t[i] != len)
               check($sformatf("u%0d sel", i), 32'(sel_w[i]),
                     (t[i] >= 0) ? 32'(t[i] / (esp[i] + 1)) : 32'd0);
            check($sformatf("u%0d ocupado", i), 32'(ocup_w[i]), 32'(t[i] >= 0));
            check($sformatf("u%0d pronto", i), 32'(pronto_w[i]), 32'(t[i] == len));
            check($sformatf("u%0d dados", i), 32'(dados_w[i]), 32'(m_dados[i]));
`ifdef VARREDOR_MUX8_PARIDADE_EN
            check($sformatf("u%0d paridade", i), 32'(par_w[i]), 32'(^m_dados[i]));
`endif
            glitch[i] = glitch_on && t[i] >= 0 && t[i] < len &&
                        (t[i] % (esp[i] + 1) != esp[i]) && ($urandom_range(1) == 1);
         end
      end
   end

   // ---------------- directed / random stimulus ----------------
   task automatic wait_pronto(input int i, input int budget, output int lat);
      lat = -1;
      for (int c = 1; c <= budget; c++) begin
         if (pronto_w[i]) begin
            lat = c - 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Starts a scan, returns edges from start to Pronto, ends in the idle cycle after.
   task automatic run_scan(input int i, output int lat);
      ini[i] = 1'b1;
      @(negedge clk);
      ini[i] = 1'b0;
      wait_pronto(i, 60, lat);
      @(negedge clk);
   endtask

   initial begin
      int lat, np, first, c;
      logic pulsed;

      // 1. Reset with Iniciar high: outputs stay at reset values.
      ini[0] = 1'b1;
      ini[1] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst sel", 32'(sel_w[0]), 32'd0);
         check("rst ocupado", 32'(ocup_w[0]), 32'd0);
         check("rst pronto", 32'(pronto_w[0]), 32'd0);
         check("rst dados", 32'(dados_w[0]), 32'h00);
      end
      // 2. Release with Iniciar still high: scan begins on the next edge.
      mux[0] = 8'hA6;
      ini[1] = 1'b0;
      rst    = 1'b0;
      run_scan(0, lat);
      check("basic latency", 32'(lat), 32'd8);
      check("basic dados", 32'(dados_w[0]), 32'hA6);
`ifdef VARREDOR_MUX8_PARIDADE_EN
      check("basic paridade", 32'(par_w[0]), 32'd0);
`endif

      // 3. Settle timing with glitches on non-final cycles.
      glitch_on = 1'b1;
      mux[1] = 8'h5B;
      run_scan(1, lat);
      check("settle latency", 32'(lat), 32'd32);
      check("settle dados", 32'(dados_w[1]), 32'h5B);

      // 4a. Busy lockout: pulse Iniciar while code 3 is selected.
      ini[0] = 1'b1;
      @(negedge clk);
      ini[0] = 1'b0;
      np = 0; first = -1; pulsed = 1'b0;
      for (c = 1; c <= 30; c++) begin
         if (!pulsed && sel_w[0] == 3'd3 && ocup_w[0]) begin
            ini[0] = 1'b1;
            pulsed = 1'b1;
         end else begin
            ini[0] = 1'b0;
         end
         if (pronto_w[0]) begin
            np++;
            if (first < 0) first = c - 1;
         end
         @(negedge clk);
      end
      check("lockout pulsed", 32'(pulsed), 32'd1);
      check("lockout pronto count", 32'(np), 32'd1);
      check("lockout latency", 32'(first), 32'd8);

      // 4b. Iniciar held high: back-to-back scans, one idle cycle between.
      ini[0] = 1'b1;
      @(negedge clk);
      wait_pronto(0, 60, lat);
      check("b2b first latency", 32'(lat), 32'd8);
      mux[0] = 8'hFF;
      @(negedge clk);
      check("b2b idle gap", 32'(ocup_w[0]), 32'd0);
      @(negedge clk);
      check("b2b restart", 32'(ocup_w[0]), 32'd1);
      wait_pronto(0, 60, lat);
      ini[0] = 1'b0;
      check("b2b second latency", 32'(lat), 32'd8);
      check("b2b dados", 32'(dados_w[0]), 32'hFF);
`ifdef VARREDOR_MUX8_PARIDADE_EN
      check("b2b paridade", 32'(par_w[0]), 32'd0);
`endif
      @(negedge clk);

      // 5. Reset mid-scan at code 5: aborted, cleared, no Pronto.
      ini[0] = 1'b1;
      @(negedge clk);
      ini[0] = 1'b0;
      for (c = 0; c < 20 && sel_w[0] != 3'd5; c++) @(negedge clk);
      check("abort reached code 5", 32'(sel_w[0]), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort sel", 32'(sel_w[0]), 32'd0);
      check("abort ocupado", 32'(ocup_w[0]), 32'd0);
      check("abort dados", 32'(dados_w[0]), 32'h00);
      np = 0;
      repeat (12) begin
         @(negedge clk);
         if (pronto_w[0]) np++;
      end
      check("abort no pronto", 32'(np), 32'd0);

      // 6. Single-bit walk.
      for (int b = 0; b < 8; b++) begin
         mux[0] = 8'(1 << b);
         run_scan(0, lat);
         check($sformatf("walk%0d dados", b), 32'(dados_w[0]), 32'(1 << b));
`ifdef VARREDOR_MUX8_PARIDADE_EN
         check($sformatf("walk%0d paridade", b), 32'(par_w[0]), 32'd1);
`endif
      end

      // Random words on both instances concurrently, glitches still enabled.
      for (int k = 0; k < 12; k++) begin
         mux[0] = 8'($urandom);
         mux[1] = 8'($urandom);
         ini[0] = 1'b1;
         ini[1] = 1'b1;
         @(negedge clk);
         ini[0] = 1'b0;
         ini[1] = 1'b0;
         repeat (36) @(negedge clk);
         check($sformatf("rand%0d u0 dados", k), 32'(dados_w[0]), 32'(mux[0]));
         check($sformatf("rand%0d u1 dados", k), 32'(dados_w[1]), 32'(mux[1]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
